keypad_scanner: RTL and testbench

//  Input-side counterpart of the 4-digit seven-segment output path: scans a 4x4 matrix keypad
//  by driving columns low one at a time and sampling the pulled-up rows. Debounces, decodes

---
 rtl/keypad_if.sv | 28 ++
 rtl/keypad_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad scanner port bundle: matrix rows/columns, clear request and the accepted-key outputs.
// The scanner takes the slave side; whatever drives the keypad and consumes digits takes master.
interface keypad_if;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] value;

  modport slave (
    input  row,
    input  clear,
    output col,
    output key,
    output key_valid,
    output value
  );

  modport master (
    output row,
    output clear,
    input  col,
    input  key,
    input  key_valid,
    input  value
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, frame-level debounce, hex decode and a
// 16-bit digit shift register in the same nibble layout the seven-segment path displays.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input logic      clk,
  input logic      reset,
  keypad_if.slave  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    PRESSED,
    REL
  } state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic          sample;
  logic          frame_end;
  logic [3:0]    pressed_now;
  logic [15:0]   frame_acc;
  logic [15:0]   frame_bits;
  logic [4:0]    ones;
  logic [3:0]    code;
  logic          single;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [3:0]    cand;
  logic [3:0]    cand_nxt;
  logic          accept;

  logic [3:0]    key_q;
  logic          key_valid_q;
  logic [15:0]   value_q;

  // Rows come straight from mechanical switches, so nothing looks at them before two flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  assign sample      = (div == DW'(SCAN_DIV - 1));
  assign frame_end   = sample && (col_idx == 2'd3);
  assign pressed_now = ~row_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div     <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign kp.col = ~(4'b0001 << col_idx);

  // Bit 4*r+c of the frame image is key (r,c); the current column is merged in combinationally
  // so that on the last column the complete frame is available on the same cycle.
  always_comb begin
    frame_bits = frame_acc;
    for (int r = 0; r < 4; r++) begin
      frame_bits[{2'(r), col_idx}] = pressed_now[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_acc <= '0;
    end else if (sample) begin
      frame_acc <= frame_bits;
    end
  end

  always_comb begin
    ones = 5'd0;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits[i]) begin
        ones = ones + 5'd1;
        code = 4'(i);
      end
    end
  end

  // Two or more keys down are never resolved, so a multi-key frame counts the same as an empty one.
  assign single = (ones == 5'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_nxt = code;
            cnt_nxt  = 4'd1;
            if (DEBOUNCE == 1) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end else begin
              state_nxt = CAND;
            end
          end
        end
        CAND: begin
          if (single && (code == cand)) begin
            cnt_nxt = cnt + 4'd1;
            if ((cnt + 4'd1) == 4'(DEBOUNCE)) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end
          end else if (single) begin
            cand_nxt = code;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        PRESSED: begin
          if (!single) begin
            cnt_nxt   = 4'd1;
            state_nxt = (DEBOUNCE == 1) ? IDLE : REL;
          end
        end
        REL: begin
          if (!single) begin
            cnt_nxt = cnt + 4'd1;
            if ((cnt + 4'd1) == 4'(DEBOUNCE)) begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = PRESSED;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // An accept coinciding with clear still keeps the new digit, so the display never goes blank on it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      value_q     <= 16'h0000;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_q <= cand_nxt;
      end
      if (accept && kp.clear) begin
        value_q <= {12'h000, cand_nxt};
      end else if (accept) begin
        value_q <= {value_q[11:0], cand_nxt};
      end else if (kp.clear) begin
        value_q <= 16'h0000;
      end
    end
  end

  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows, and a frame-level run-length
// model of press/release acceptance predicts col/key/key_valid/value on every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = 16'h0000;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.slave)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      kp.row[r] = ~|(keys[4*r +: 4] & ~kp.col);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Acceptance model: a key is taken when DEB consecutive frames show that same lone key while
  // armed; arming needs DEB consecutive frames without a lone key (or a reset).
  bit          started = 1'b0;
  int          pos;
  bit          armed;
  int          run_len;
  int          run_key;
  int          none_run;
  bit          acc;
  logic [3:0]  m_key;
  logic        m_kv;
  logic [15:0] m_value;
  logic [3:0]  m_col;

  always @(posedge clk) begin
    if (!reset) begin
      pos = 0; armed = 1'b1; run_len = 0; run_key = 0; none_run = 0;
      m_key = 4'd0; m_kv = 1'b0; m_value = 16'h0000; m_col = 4'b1110;
      started = 1'b1;
    end else begin
      acc  = 1'b0;
      m_kv = 1'b0;
      if (pos == FRAME - 1) begin
        if ($countones(keys) == 1) begin
          int k;
          k = 0;
          for (int i = 0; i < 16; i++) if (keys[i]) k = i;
          none_run = 0;
          if (run_len > 0 && run_key == k) run_len++;
          else begin run_key = k; run_len = 1; end
          if (armed && run_len == DEB) begin acc = 1'b1; armed = 1'b0; end
        end else begin
          run_len = 0;
          none_run++;
          if (!armed && none_run >= DEB) armed = 1'b1;
        end
      end
      if (acc) begin
        m_key   = 4'(run_key);
        m_kv    = 1'b1;
        m_value = kp.clear ? {12'h000, 4'(run_key)} : {m_value[11:0], 4'(run_key)};
      end else if (kp.clear) begin
        m_value = 16'h0000;
      end
      pos   = (pos + 1) % FRAME;
      m_col = ~(4'b0001 << (pos / SCAN_DIV));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("col", {12'h000, kp.col}, {12'h000, m_col});
      checkOutput("key", {12'h000, kp.key}, {12'h000, m_key});
      checkOutput("key_valid", {15'h0, kp.key_valid}, {15'h0, m_kv});
      checkOutput("value", kp.value, m_value);
      if (kp.key_valid) pulses++;
    end
  end

  // Holds a key mask for whole frames; every call starts and ends on a frame boundary.
  task automatic applyStimulus(input logic [15:0] mask, input int frames, input bit clr_en);
    keys = mask;
    for (int i = 0; i < frames * FRAME; i++) begin
      kp.clear = clr_en && ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    kp.clear = 1'b0;
  endtask

  task automatic holdReset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] col_seq [4];
    int p0;
    logic [15:0] mask;
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;
    kp.clear = 1'b0;

    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset col", {12'h000, kp.col}, 16'h000E);
    checkOutput("reset key", {12'h000, kp.key}, 16'h0000);
    checkOutput("reset key_valid", {15'h0, kp.key_valid}, 16'h0000);
    checkOutput("reset value", kp.value, 16'h0000);
    reset = 1'b1;
    for (int c = 1; c < 4; c++) begin
      repeat (SCAN_DIV) @(posedge clk);
      #1;
      checkOutput("col step", {12'h000, kp.col}, {12'h000, col_seq[c]});
    end
    repeat (SCAN_DIV) @(posedge clk);
    #1;

    p0 = pulses;
    applyStimulus(16'h0040, 6, 1'b0);
    applyStimulus(16'h0000, 4, 1'b0);
    checkOutput("key6 pulses", 16'(pulses - p0), 16'd1);
    checkOutput("key6 key", {12'h000, kp.key}, 16'h0006);
    checkOutput("key6 value", kp.value, 16'h0006);

    p0 = pulses;
    for (int d = 1; d <= 5; d++) begin
      mask = 16'h0001 << d;
      applyStimulus(mask, 4, 1'b0);
      applyStimulus(16'h0000, 4, 1'b0);
    end
    checkOutput("digits pulses", 16'(pulses - p0), 16'd5);
    checkOutput("digits value", kp.value, 16'h2345);

    p0 = pulses;
    applyStimulus(16'h0040, 2, 1'b0);
    applyStimulus(16'h0000, 4, 1'b0);
    checkOutput("short press pulses", 16'(pulses - p0), 16'd0);
    applyStimulus(16'h0040, 4, 1'b0);
    applyStimulus(16'h0000, 1, 1'b0);
    applyStimulus(16'h0040, 1, 1'b0);
    applyStimulus(16'h0000, 1, 1'b0);
    applyStimulus(16'h0040, 1, 1'b0);
    applyStimulus(16'h0000, 4, 1'b0);
    checkOutput("bounce pulses", 16'(pulses - p0), 16'd1);

    p0 = pulses;
    applyStimulus(16'h0021, 5, 1'b0);
    checkOutput("multi pulses", 16'(pulses - p0), 16'd0);
    applyStimulus(16'h0001, 3, 1'b0);
    checkOutput("key0 key_valid", {15'h0, kp.key_valid}, 16'h0001);
    checkOutput("key0 key", {12'h000, kp.key}, 16'h0000);
    applyStimulus(16'h0000, 4, 1'b0);

    applyStimulus(16'h0200, 2, 1'b0);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    kp.clear = 1'b1;
    @(posedge clk);
    #1;
    kp.clear = 1'b0;
    checkOutput("clear+accept key_valid", {15'h0, kp.key_valid}, 16'h0001);
    checkOutput("clear+accept value", kp.value, 16'h0009);
    applyStimulus(16'h0200, 2, 1'b0);
    holdReset(5);
    checkOutput("midpress reset col", {12'h000, kp.col}, 16'h000E);
    checkOutput("midpress reset value", kp.value, 16'h0000);
    applyStimulus(16'h0200, 3, 1'b0);
    checkOutput("reaccept key_valid", {15'h0, kp.key_valid}, 16'h0001);
    checkOutput("reaccept key", {12'h000, kp.key}, 16'h0009);
    checkOutput("reaccept value", kp.value, 16'h0009);
    applyStimulus(16'h0000, 4, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int sel;
      int a;
      int b;
      sel = $urandom_range(0, 9);
      a   = $urandom_range(0, 15);
      b   = (a + $urandom_range(1, 15)) % 16;
      if (sel < 4)       mask = 16'h0000;
      else if (sel < 9)  mask = 16'h0001 << a;
      else               mask = (16'h0001 << a) | (16'h0001 << b);
      applyStimulus(mask, $urandom_range(1, 5), 1'b1);
    end
    applyStimulus(16'h0000, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
